vdcmul_acc: RTL and testbench
=============================

VDCMUL_ACC -- requirements
Module: vdcmul_acc

Interface
REQ-001 Parameter ACC_W, default 12: accumulator and sum width in bits, minimum 8.
REQ-002 Parameter MAX_TERMS, default 16: maximum products per accumulation group, minimum 1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  an upstream 8-bit product is presented.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 in_prod  input  8  unsigned product from the 4x4 multiplier stage.
REQ-009 in_last  input  1  the presented product closes the current group.
REQ-010 out_valid  output  1  group result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sum  output  ACC_W  accumulated group sum.
REQ-013 out_count  output  CNT_W=$clog2(MAX_TERMS+1)  number of products in the group.
REQ-014 out_ovf  output  1  sticky: at least one addition in the group exceeded ACC_W bits.

Function
REQ-015 The block SHALL have three states: IDLE (no partial sum), ACC (partial sum held) and DONE (result held).
REQ-016 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; it SHALL depend only on state.
REQ-017 A beat is accepted when in_valid && in_ready; the block SHALL ignore in_prod and in_last on all other cycles.
REQ-018 Accept in IDLE: acc <= zero-extended in_prod; count <= 1; ovf <= 0.
REQ-019 Accept in ACC: acc <= acc + in_prod; count <= count + 1; ovf <= ovf OR carry-out.
REQ-020 After an accept, the next state SHALL be DONE if in_last=1 or the new count equals MAX_TERMS, and ACC otherwise.
REQ-021 out_valid SHALL be 1 exactly while in DONE, so the result is valid 1 cycle after the closing beat.
REQ-022 out_sum, out_count and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid && out_ready, the state SHALL go to IDLE; the first new beat can be accepted on the following cycle.
REQ-024 Without an accepted beat, IDLE and ACC SHALL hold their state and register contents indefinitely.
REQ-025 Arithmetic SHALL be unsigned, and the adder SHALL be ACC_W+1 bits wide, with the MSB used as carry-out.

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE with acc=0, count=0, ovf=0, out_valid=0 and in_ready=1.
REQ-027 When reset is asserted mid-group or in DONE, the block SHALL discard the partial or held result without emitting it.

Configuration
REQ-028 With macro VDCMUL_ACC_SATURATE_EN defined, an addition with carry-out SHALL load all-ones into acc and set ovf.
REQ-029 Without VDCMUL_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W, and ovf SHALL still be set on carry-out.

Structure
REQ-030 Package vdcmul_pkg SHALL hold the state enum (IDLE, ACC, DONE) and the default constants ACC_W_DEF=12 and MAX_TERMS_DEF=16.
REQ-031 The sub-module vdcmul_acc_add SHALL contain the combinational ACC_W adder, carry-out and optional saturation; the FSM and registers SHALL stay in vdcmul_acc.

Verification
REQ-032 Beats 225, 10, 20 (last on 20), out_ready=1 -> out_valid 1 cycle after the 20 beat, with out_sum=255, out_count=3 and out_ovf=0.
REQ-033 16 beats of value 1 with in_last=0 -> automatic close, out_sum=16, out_count=16; beat 17 is accepted only after the output handshake.
REQ-034 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable, no beat lost; the first beat after release starts a new group with count=1.
REQ-035 ACC_W=10, five beats of 225 (last on the fifth) -> wrap build: out_sum=101, out_ovf=1; VDCMUL_ACC_SATURATE_EN build: out_sum=1023, out_ovf=1.
REQ-036 Reset pulsed after 2 of 4 beats -> no out_valid; a following group of 7, 8 (last) -> out_sum=15, out_count=2.
REQ-037 A single beat 0x00 with in_last=1 in IDLE -> DONE next cycle, out_sum=0, out_count=1.

Source files
------------

// File: rtl/vdcmul_pkg.sv
// vdcmul_pkg: shared state encoding and default sizing for the vdcmul_acc
// product accumulator.
package vdcmul_pkg;

  localparam int ACC_W_DEF     = 12;
  localparam int MAX_TERMS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to hold a product count from 0 up to max_terms inclusive.
  function automatic int cnt_w(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage

// File: rtl/vdcmul_acc_if.sv
// vdcmul_acc_if: product input stream plus group-result output stream.
// master = upstream/downstream side, slave = the accumulator.
interface vdcmul_acc_if
  import vdcmul_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) ();

  localparam int CNT_W = cnt_w(MAX_TERMS);

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/vdcmul_acc_add.sv
// vdcmul_acc_add: combinational ACC_W+1 bit unsigned adder for the running
// sum. The MSB of the wide sum is the carry-out. With VDCMUL_ACC_SATURATE_EN
// defined, a carry forces the result to all-ones; otherwise it wraps.
module vdcmul_acc_add
  import vdcmul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [7:0]       i_prod,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W - 7){1'b0}}, i_prod};
  assign o_carry = w_full[ACC_W];

`ifdef VDCMUL_ACC_SATURATE_EN
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/vdcmul_acc.sv
// vdcmul_acc: groups unsigned 8-bit products into sums. A group closes on
// in_last or when MAX_TERMS products have been taken; the result is held
// until the downstream handshake. Optional macro: VDCMUL_ACC_SATURATE_EN
// (saturate the sum on overflow instead of wrapping).
//
// state | meaning
// IDLE  | no partial sum, next beat starts a group
// ACC   | partial sum held, more beats expected
// DONE  | result held on the output, input stalled
module vdcmul_acc
  import vdcmul_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  vdcmul_acc_if.slave  bus
);

  localparam int CNT_W = cnt_w(MAX_TERMS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_close;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_carry;

  assign w_in_ready  = (r_state != DONE);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_count_nxt = (r_state == IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_close     = bus.in_last || (w_count_nxt == CNT_W'(MAX_TERMS));

  vdcmul_acc_add #(.ACC_W(ACC_W)) u_add (
    .i_acc   (r_acc),
    .i_prod  (bus.in_prod),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: close on last/full, release on output handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACC: if (w_accept) w_state_nxt = w_close ? DONE : ACC;
      DONE:      if (bus.out_ready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Sum, count and sticky overflow; a new group restarts from the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_count <= w_count_nxt;
      if (r_state == IDLE) begin
        r_acc <= ACC_W'(bus.in_prod);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_add_sum;
        r_ovf <= r_ovf | w_add_carry;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_count;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_vdcmul_acc.sv
// tb_vdcmul_acc: directed bench for vdcmul_acc with a result scoreboard.
// A 12-bit default instance carries the main sequence; a 10-bit instance
// exercises overflow (wrap or saturate depending on VDCMUL_ACC_SATURATE_EN).
module tb_vdcmul_acc;

  typedef struct {
    logic [11:0] sum;
    logic [4:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  vdcmul_acc_if #(.ACC_W(12), .MAX_TERMS(16)) bus ();
  vdcmul_acc_if #(.ACC_W(10), .MAX_TERMS(16)) bus10 ();

  vdcmul_acc #(.ACC_W(12), .MAX_TERMS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vdcmul_acc #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one beat (inputs change 1 time unit after a rising edge) and
  // return just after the edge that accepts it.
  task automatic beat(input logic [7:0] p, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = l;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $error("FAIL beat_timeout observed=%0d expected=%0d", n, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_prod  = 8'hxx;
    bus.in_last  = 1'bx;
  endtask

  // Scoreboard: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(bus.out_sum), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sum",   32'(bus.out_sum),   32'(e.sum));
        chk("sb_count", 32'(bus.out_count), 32'(e.cnt));
        chk("sb_ovf",   32'(bus.out_ovf),   32'(e.ovf));
      end
    end
  end

  initial begin
    logic [9:0] exp10;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_prod     = 8'd0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b0;
    bus10.in_valid  = 1'b0;
    bus10.in_prod   = 8'd0;
    bus10.in_last   = 1'b0;
    bus10.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum",       32'(bus.out_sum),   0);
    chk("rst_count",     32'(bus.out_count), 0);
    chk("rst_ovf",       32'(bus.out_ovf),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 225 + 10 + 20, result one cycle after the closing beat
    bus.out_ready = 1'b1;
    sb.push_back('{sum: 12'd255, cnt: 5'd3, ovf: 1'b0});
    beat(8'd225, 1'b0);
    chk("g1_not_done", 32'(bus.out_valid), 0);
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b1);
    idle();
    chk("g1_latency", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    chk("g1_released", 32'(bus.out_valid), 0);
    chk("g1_ready_again", 32'(bus.in_ready), 1);

    // 16 ones auto-close; beat 17 held through 5 stalled cycles
    bus.out_ready = 1'b0;
    sb.push_back('{sum: 12'd16, cnt: 5'd16, ovf: 1'b0});
    sb.push_back('{sum: 12'd1,  cnt: 5'd1,  ovf: 1'b0});
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("g2_acc_before_full", 32'(bus.out_valid), 0);
      beat(8'd1, 1'b0);
    end
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd1;
    bus.in_last  = 1'b1;
    chk("g2_autoclose", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("g2_stall_ready", 32'(bus.in_ready),  0);
      chk("g2_stall_sum",   32'(bus.out_sum),   16);
      chk("g2_stall_count", 32'(bus.out_count), 16);
      chk("g2_stall_valid", 32'(bus.out_valid), 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("g2_idle_valid", 32'(bus.out_valid), 0);
    chk("g2_idle_ready", 32'(bus.in_ready),  1);
    @(posedge clk); #1;
    idle();
    chk("g3_single_done", 32'(bus.out_valid), 1);
    chk("g3_count_one",   32'(bus.out_count), 1);
    @(posedge clk); #1;

    // Single zero beat with last
    sb.push_back('{sum: 12'd0, cnt: 5'd1, ovf: 1'b0});
    beat(8'd0, 1'b1);
    idle();
    chk("g4_zero_done", 32'(bus.out_valid), 1);
    @(posedge clk); #1;

    // Reset after 2 of 4 beats discards the group
    beat(8'd7, 1'b0);
    beat(8'd9, 1'b0);
    idle();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_ready", 32'(bus.in_ready),  1);
    chk("mid_rst_count", 32'(bus.out_count), 0);
    chk("mid_rst_sum",   32'(bus.out_sum),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    sb.push_back('{sum: 12'd15, cnt: 5'd2, ovf: 1'b0});
    beat(8'd7, 1'b0);
    beat(8'd8, 1'b1);
    idle();
    chk("g5_done", 32'(bus.out_valid), 1);
    @(posedge clk); #1;

    // 10-bit instance: five beats of 225 overflow
`ifdef VDCMUL_ACC_SATURATE_EN
    exp10 = 10'd1023;
`else
    exp10 = 10'd101;
`endif
    for (int i = 0; i < 5; i++) begin
      bus10.in_valid = 1'b1;
      bus10.in_prod  = 8'd225;
      bus10.in_last  = (i == 4);
      @(posedge clk); #1;
      if (i == 3) chk("w10_no_ovf_yet", 32'(bus10.out_ovf), 0);
    end
    bus10.in_valid = 1'b0;
    chk("w10_valid", 32'(bus10.out_valid), 1);
    chk("w10_sum",   32'(bus10.out_sum),   32'(exp10));
    chk("w10_ovf",   32'(bus10.out_ovf),   1);
    chk("w10_count", 32'(bus10.out_count), 5);
    @(posedge clk); #1;
    bus10.in_valid = 1'b1;
    bus10.in_prod  = 8'd3;
    bus10.in_last  = 1'b1;
    @(posedge clk); #1;
    bus10.in_valid = 1'b0;
    chk("w10_next_sum", 32'(bus10.out_sum), 3);
    chk("w10_ovf_clr",  32'(bus10.out_ovf), 0);
    @(posedge clk); #1;

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=%0t expected=finish", $time);
    $fatal(1, "time limit");
  end

endmodule
